mem_store_merge: RTL and testbench
==================================

MEM_STORE_MERGE -- requirements
Module: mem_store_merge

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req  in  1  store request, sampled only in IDLE.
REQ-004 SHALL have ports: op  in  2  store type: 2'b00 SW, 2'b01 SH, 2'b10 SB, 2'b11 none.
REQ-005 SHALL have ports: addr  in  32  byte address of store.
REQ-006 SHALL have ports: wdata  in  32  store data, right-justified for SH/SB.
REQ-007 SHALL have ports: busy  out  1  high whenever state is not IDLE.
REQ-008 SHALL have ports: done  out  1  one-cycle pulse on completion.
REQ-009 SHALL have ports: err  out  1  one-cycle misalignment pulse (constant 0 when the macro is absent).
REQ-010 SHALL have ports: mem_addr  out  32  word address, bits [1:0] always 0.
REQ-011 SHALL have ports: mem_rd  out  1  word read strobe; mem_rdata valid the following cycle.
REQ-012 SHALL have ports: mem_rdata  in  32  read data from word memory.
REQ-013 SHALL have ports: mem_wr  out  1  word write strobe.
REQ-014 SHALL have ports: mem_wdata  out  32  full word to write.

Function
REQ-015 SHALL implement FSM states IDLE, READ, MERGE, WRITE.
REQ-016 SHALL, in IDLE with req=1, register op, addr and wdata (cycle N); req while busy is ignored.
REQ-017 SHALL go IDLE->WRITE for SW, setting mem_wdata=wdata and asserting mem_wr in cycle N+1.
REQ-018 SHALL go IDLE->READ->MERGE->WRITE->IDLE for SH/SB: mem_rd in N+1, mem_rdata captured in N+2, mem_wr in N+3.
REQ-019 SHALL, for SB, replace byte lane addr[1:0] (0 = bits 7:0 ... 3 = bits 31:24) of the read word with wdata[7:0] and keep the other lanes unchanged.
REQ-020 SHALL, for SH, replace bits 31:16 (addr[1]=1) or 15:0 (addr[1]=0) with wdata[15:0] and keep the other half unchanged.
REQ-021 SHALL drive mem_addr={addr[31:2],2'b00} from captured addr during READ and WRITE.
REQ-022 SHALL assert done in the same cycle as mem_wr, then return to IDLE; a new req is accepted in the next cycle.
REQ-023 SHALL, for op=2'b11, perform no memory access and pulse done in N+1.
REQ-024 SHALL keep mem_rd and mem_wr mutually exclusive and each high for exactly one cycle per store.
REQ-025 SHALL leave mem_wdata at its last value outside WRITE; it is don't-care when mem_wr=0.

Reset
REQ-026 SHALL, on rst_n low, immediately enter IDLE and drive busy, done, err, mem_rd and mem_wr to 0, and mem_addr and mem_wdata to 0.
REQ-027 SHALL abort any in-flight store on reset with no write issued, including a reset asserted during MERGE.
REQ-028 SHALL ignore req in the first cycle after rst_n rises only if req is low; no other warm-up is required.

Configuration
REQ-029 SHALL, with ALIGN_CHECK_EN defined, treat SW with addr[1:0]!=0 and SH with addr[0]=1 as misaligned: no memory access, err=1 in N+1, done stays 0, return to IDLE.
REQ-030 SHALL, without ALIGN_CHECK_EN, tie err to 0, ignore addr[1:0] for SW and addr[0] for SH, and complete normally.

Verification
REQ-031 SHALL cover: SW addr=0x100, wdata=0xDEADBEEF -> N+1 mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; mem_rd never asserted.
REQ-032 SHALL cover: SB addr=0x203, wdata=0x000000AB, mem_rdata=0x11223344 -> mem_rd at N+1, N+3 mem_wdata=0xAB223344, done=1.
REQ-033 SHALL cover: SH addr=0x202, wdata=0x0000CAFE, mem_rdata=0x11223344 -> N+3 mem_wdata=0xCAFE3344 (SH addr=0x200 gives 0x1122CAFE).
REQ-034 SHALL cover: req held high continuously during an SB -> the second request is accepted only in the cycle after done; no request is lost or duplicated.
REQ-035 SHALL cover: rst_n pulsed low in MERGE of an SB -> no mem_wr, all outputs 0, next SW completes normally.
REQ-036 SHALL cover: SW addr=0x101 -> with ALIGN_CHECK_EN err=1, no mem_rd/mem_wr, done=0; without the macro mem_addr=0x100 written, err=0.

Source files
------------

// File: rtl/mem_store_merge.sv
// mem_store_merge: store unit for a word-only memory. SW writes the word
// directly; SH/SB perform read-modify-write (READ -> MERGE -> WRITE).
// Optional feature: define ALIGN_CHECK_EN to reject misaligned SW/SH with a
// one-cycle err pulse instead of a memory access. Without it, err is always 0.
module mem_store_merge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_e;

  state_e      state_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  // Only the parts of the request needed by the merge are kept.
  logic        half_q;
  logic [1:0]  lane_q;
  logic [15:0] wlo_q;

  logic        misalign;
  logic [31:0] merged;

  // Alignment screen applied to the incoming request
  always_comb begin
    misalign = 1'b0;
`ifdef ALIGN_CHECK_EN
    misalign = ((op == OP_SW) && (addr[1:0] != 2'b00)) ||
               ((op == OP_SH) && addr[0]);
`endif
  end

  // Insert the captured halfword/byte into the word returned by memory
  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = wlo_q;
      else           merged[15:0]  = wlo_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wlo_q[7:0];
        2'd1:    merged[15:8]  = wlo_q[7:0];
        2'd2:    merged[23:16] = wlo_q[7:0];
        default: merged[31:24] = wlo_q[7:0];
      endcase
    end
  end

  // Store sequencer with registered outputs; strobes default low each cycle.
  // NOP and misaligned requests pass through WRITE without a memory strobe so
  // that every accepted request spends exactly one busy completion cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      half_q      <= 1'b0;
      lane_q      <= '0;
      wlo_q       <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            half_q  <= (op == OP_SH);
            lane_q  <= addr[1:0];
            wlo_q   <= wdata[15:0];
            busy_q  <= 1'b1;
            state_q <= WRITE;
            if (misalign) begin
              err_q <= 1'b1;
            end else begin
              case (op)
                OP_SW: begin
                  mem_addr_q  <= {addr[31:2], 2'b00};
                  mem_wdata_q <= wdata;
                  mem_wr_q    <= 1'b1;
                  done_q      <= 1'b1;
                end
                OP_SH, OP_SB: begin
                  mem_addr_q <= {addr[31:2], 2'b00};
                  mem_rd_q   <= 1'b1;
                  state_q    <= READ;
                end
                default: begin
                  done_q <= 1'b1;
                end
              endcase
            end
          end
        end
        READ: begin
          state_q <= MERGE;
        end
        MERGE: begin
          mem_wdata_q <= merged;
          mem_wr_q    <= 1'b1;
          done_q      <= 1'b1;
          state_q     <= WRITE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_store_merge.sv
// tb_mem_store_merge: randomized and directed checks of mem_store_merge
// against a word-array reference model. Honors ALIGN_CHECK_EN if defined.
module tb_mem_store_merge;

  localparam logic [1:0] SW  = 2'b00;
  localparam logic [1:0] SH  = 2'b01;
  localparam logic [1:0] SB  = 2'b10;
  localparam logic [1:0] NOP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b11;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  int k, rd_n, wr_n, done_n, err_n, rd_at, wr_at, first_wr_at, done_at, err_at;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic        busy1, busy_last;

  mem_store_merge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  // Word memory: read data valid the cycle after mem_rd
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= dev_mem[mem_addr[9:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    k = 0; rd_n = 0; wr_n = 0; done_n = 0; err_n = 0;
    rd_at = 0; wr_at = 0; first_wr_at = 0; done_at = 0; err_at = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    busy1 = 1'b0; busy_last = 1'b0;
  endtask

  // Advance to the next falling edge and log what the DUT presents
  task automatic tick();
    @(negedge clk);
    k++;
    if (mem_rd) begin rd_n++; rd_at = k; rd_addr = mem_addr; end
    if (mem_wr) begin
      wr_n++;
      if (first_wr_at == 0) first_wr_at = k;
      wr_at = k; wr_addr = mem_addr; wr_data = mem_wdata;
      dev_mem[mem_addr[9:2]] = mem_wdata;
    end
    if (done) begin done_n++; done_at = k; end
    if (err)  begin err_n++;  err_at = k;  end
    if (k == 1) busy1 = busy;
    busy_last = busy;
    check_eq("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_busy"},  {31'b0, busy},   32'd0);
    check_eq({pfx, "_done"},  {31'b0, done},   32'd0);
    check_eq({pfx, "_err"},   {31'b0, err},    32'd0);
    check_eq({pfx, "_rd"},    {31'b0, mem_rd}, 32'd0);
    check_eq({pfx, "_wr"},    {31'b0, mem_wr}, 32'd0);
    check_eq({pfx, "_addr"},  mem_addr,        32'd0);
    check_eq({pfx, "_wdata"}, mem_wdata,       32'd0);
  endtask

  task automatic set_word(input logic [7:0] idx, input logic [31:0] v);
    dev_mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  // Reference: replace the addressed byte/halfword of the old word
  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] o,
                                               input logic [31:0] a, input logic [31:0] d);
    int unsigned sh;
    logic [31:0] mask;
    if (o == SB) begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
      return (old & ~mask) | ((d & 32'h0000_00FF) << sh);
    end
    sh   = 16 * int'(a[1]);
    mask = 32'h0000_FFFF << sh;
    return (old & ~mask) | ((d & 32'h0000_FFFF) << sh);
  endfunction

  function automatic bit is_misaligned(input logic [1:0] o, input logic [31:0] a);
    bit m;
    m = 1'b0;
`ifdef ALIGN_CHECK_EN
    m = ((o == SW) && (a % 4 != 0)) || ((o == SH) && (a % 2 != 0));
`endif
    return m;
  endfunction

  // One request issued at a falling edge, observed over cycles N+1..N+4
  task automatic run_store(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] wd_obs);
    logic [7:0]  idx;
    logic [31:0] exp_word;
    bit          mis;
    idx = a[9:2];
    mis = is_misaligned(o, a);
    exp_word = (o == SW) ? d : model_store(ref_mem[idx], o, a, d);
    clear_log();
    req = 1'b1; op = o; addr = a; wdata = d;
    tick();
    req = 1'b0; op = NOP; addr = $urandom; wdata = $urandom;
    repeat (3) tick();
    if (mis) begin
      check_eq("mis_err_n",   err_n,  1);
      check_eq("mis_err_at",  err_at, 1);
      check_eq("mis_done_n",  done_n, 0);
      check_eq("mis_rd_n",    rd_n,   0);
      check_eq("mis_wr_n",    wr_n,   0);
    end else if (o == NOP) begin
      check_eq("nop_done_n",  done_n, 1);
      check_eq("nop_done_at", done_at, 1);
      check_eq("nop_rd_n",    rd_n,   0);
      check_eq("nop_wr_n",    wr_n,   0);
      check_eq("nop_err_n",   err_n,  0);
    end else begin
      check_eq("st_busy1",   {31'b0, busy1}, 1);
      check_eq("st_wr_n",    wr_n,   1);
      check_eq("st_done_n",  done_n, 1);
      check_eq("st_err_n",   err_n,  0);
      check_eq("st_wr_addr", wr_addr, a & 32'hFFFF_FFFC);
      check_eq("st_wr_data", wr_data, exp_word);
      if (o == SW) begin
        check_eq("sw_rd_n",    rd_n,    0);
        check_eq("sw_wr_at",   wr_at,   1);
        check_eq("sw_done_at", done_at, 1);
      end else begin
        check_eq("rmw_rd_n",    rd_n,    1);
        check_eq("rmw_rd_at",   rd_at,   1);
        check_eq("rmw_rd_addr", rd_addr, a & 32'hFFFF_FFFC);
        check_eq("rmw_wr_at",   wr_at,   3);
        check_eq("rmw_done_at", done_at, 3);
      end
      ref_mem[idx] = exp_word;
    end
    check_eq("idle_busy4", {31'b0, busy_last}, 0);
    wd_obs = wr_data;
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] d1, d2, exp1;

    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed stores with known results
    run_store(SW, 32'h0000_0100, 32'hDEAD_BEEF, obs);
    check_eq("sw_dir", obs, 32'hDEAD_BEEF);
    set_word(8'h80, 32'h1122_3344);
    run_store(SB, 32'h0000_0203, 32'h0000_00AB, obs);
    check_eq("sb_dir", obs, 32'hAB22_3344);
    set_word(8'h80, 32'h1122_3344);
    run_store(SH, 32'h0000_0202, 32'h0000_CAFE, obs);
    check_eq("sh_hi_dir", obs, 32'hCAFE_3344);
    set_word(8'h80, 32'h1122_3344);
    run_store(SH, 32'h0000_0200, 32'h0000_CAFE, obs);
    check_eq("sh_lo_dir", obs, 32'h1122_CAFE);
    run_store(NOP, 32'h0000_0300, 32'h1234_5678, obs);
    run_store(SW, 32'h0000_0101, 32'h5555_AAAA, obs);
`ifndef ALIGN_CHECK_EN
    check_eq("sw_unaligned_dir", obs, 32'h5555_AAAA);
`endif

    // req held high through an SB, then a SW queued behind it
    d1 = $urandom; d2 = $urandom;
    exp1 = model_store(ref_mem[8'h11], SB, 32'h0000_0045, d1);
    clear_log();
    req = 1'b1; op = SB; addr = 32'h0000_0045; wdata = d1;
    repeat (3) tick();
    op = SW; addr = 32'h0000_0088; wdata = d2;
    repeat (2) tick();
    req = 1'b0; op = NOP;
    repeat (2) tick();
    check_eq("hold_rd_n",     rd_n, 1);
    check_eq("hold_rd_at",    rd_at, 1);
    check_eq("hold_wr_n",     wr_n, 2);
    check_eq("hold_wr1_at",   first_wr_at, 3);
    check_eq("hold_wr2_at",   wr_at, 5);
    check_eq("hold_done_n",   done_n, 2);
    check_eq("hold_sb_word",  dev_mem[8'h11], exp1);
    check_eq("hold_sw_addr",  wr_addr, 32'h0000_0088);
    check_eq("hold_sw_data",  wr_data, d2);
    check_eq("hold_idle",     {31'b0, busy_last}, 0);
    ref_mem[8'h11] = exp1;
    ref_mem[8'h22] = d2;

    // Reset pulse while an SB sits in MERGE
    clear_log();
    req = 1'b1; op = SB; addr = 32'h0000_0302; wdata = $urandom;
    tick();
    req = 1'b0; op = NOP;
    tick();
    rst_n = 1'b0;
    #1 check_zero("rst_merge");
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("rst_no_wr",   wr_n, 0);
    check_eq("rst_no_done", done_n, 0);
    check_eq("rst_mem",     dev_mem[8'hC0], ref_mem[8'hC0]);
    d1 = $urandom;
    run_store(SW, 32'h0000_0304, d1, obs);
    check_eq("post_rst_sw", obs, d1);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      run_store(2'($urandom_range(0, 3)), $urandom, $urandom, obs);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
